imem_latency_model: RTL and testbench

IMEM_LATENCY_MODEL -- requirements
Module: imem_latency_model

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_latency_model_if.sv | 23 ++
 rtl/imem_array.sv | 21 ++
 rtl/imem_latency_model.sv | 113 +++++++++++
 tb/tb_imem_latency_model.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared FSM encoding and constants for the instruction memory latency model.
package imem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } imem_state_t;

  localparam logic [31:0] IMEM_NOP    = 32'h0000_0013;
  localparam int          DEF_LATENCY = 3;
  localparam int          DEF_DEPTH   = 256;

endpackage

// File: rtl/imem_latency_model_if.sv
// Fetch and preload bus between a CPU-side driver (master) and the latency model (slave).
interface imem_latency_model_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instruction;
  logic              busywait;
  logic              err;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (
    output address, load_en, load_addr, load_data,
    input  instruction, busywait, err
  );

  modport slave (
    input  address, load_en, load_addr, load_data,
    output instruction, busywait, err
  );
endinterface

// File: rtl/imem_array.sv
// Word storage: one synchronous write port, one asynchronous read port, no reset.
module imem_array #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_latency_model.sv
// Instruction memory with a fixed fetch latency, redirect restart and load coherence.
// Define IMEM_ERR_CHECK_EN to flag misaligned / out-of-range fetches (served as NOP).
module imem_latency_model
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input logic                 CLK,
  input logic                 RESET,
  imem_latency_model_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

  imem_state_t       state;
  logic [ADDR_W-1:0] served_addr;
  logic [ADDR_W-1:0] req_addr;
  logic              served_valid;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] rd_data;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  load_idx;
  logic [IDX_W-1:0]  served_idx;
  logic              busy;
  logic              load_we;
  logic              load_hits_req;
  logic              unused_load;

  assign req_idx       = req_addr[IDX_W+1:2];
  assign load_idx      = bus.load_addr[IDX_W+1:2];
  assign served_idx    = served_addr[IDX_W+1:2];
  assign load_we       = bus.load_en && !RESET;
  assign load_hits_req = load_we && (load_idx == req_idx);
  assign busy          = !(served_valid && (bus.address == served_addr));
  assign unused_load   = ^bus.load_addr;

  assign bus.busywait    = busy;
  assign bus.instruction = instr_q;

`ifdef IMEM_ERR_CHECK_EN
  logic err_q;
  logic bad_addr;
  assign bad_addr = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);
  assign bus.err  = err_q;
`else
  assign bus.err  = 1'b0;
`endif

  imem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_array (
    .clk  (CLK),
    .we   (load_we),
    .waddr(load_idx),
    .wdata(bus.load_data),
    .raddr(req_idx),
    .rdata(rd_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      served_valid <= 1'b0;
      served_addr  <= '0;
      req_addr     <= '0;
      cnt          <= '0;
      instr_q      <= '0;
`ifdef IMEM_ERR_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      // A load over the served word forces a refetch; a completion below overrides this.
      if (load_we && (load_idx == served_idx)) served_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (busy) begin
            state    <= WAIT;
            req_addr <= bus.address;
            cnt      <= CNT_RELOAD;
          end
        end
        WAIT: begin
          if (bus.address != req_addr) begin
            req_addr <= bus.address;
            cnt      <= CNT_RELOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (load_hits_req) begin
            // Word changed under the fetch: restart so the new data pays full latency.
            cnt <= CNT_RELOAD;
          end else begin
`ifdef IMEM_ERR_CHECK_EN
            instr_q <= bad_addr ? DATA_W'(IMEM_NOP) : rd_data;
            err_q   <= bad_addr;
`else
            instr_q <= rd_data;
`endif
            served_addr  <= req_addr;
            served_valid <= 1'b1;
            state        <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_latency_model.sv
// Directed bench for imem_latency_model: expected words queued at fetch launch, checked at completion.
module tb_imem_latency_model;
  import imem_pkg::*;

  localparam int          LAT  = 3;
  localparam int          FULL = LAT + 1;
  localparam logic [31:0] M0   = 32'h0010_8093;
  localparam logic [31:0] M1   = 32'h0030_8113;
  localparam logic [31:0] M2   = 32'h00a0_0193;
  localparam logic [31:0] M4   = 32'h0050_0293;
  localparam logic [31:0] M5A  = 32'hAAAA_5555;
  localparam logic [31:0] M5B  = 32'hBBBB_0000;
  localparam logic [31:0] M8A  = 32'hC1C1_0001;
  localparam logic [31:0] M8B  = 32'hC2C2_0002;
  localparam logic [31:0] M16  = 32'h02a0_0213;

  logic        CLK = 1'b0;
  logic        RESET;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [31:0] last_instr;
  logic        last_err;

  imem_latency_model_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_latency_model #(
    .ADDR_W (32),
    .DATA_W (32),
    .DEPTH  (256),
    .LATENCY(LAT)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    next_cycle();
    bus.load_en   = 1'b0;
  endtask

  // Hold address a until busywait drops; optionally strobe a load in busy cycle ld_cyc.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp_i,
                       input logic exp_e, input int exp_busy, input int ld_cyc,
                       input logic [31:0] ld_a, input logic [31:0] ld_d);
    int          n;
    bit          done;
    logic [32:0] e;
    logic [31:0] obs_i;
    logic        obs_e;
    exp_q.push_back({exp_e, exp_i});
    bus.address = a;
    n = 0;
    done = 1'b0;
    obs_i = '0;
    obs_e = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      bus.load_en   = (c == ld_cyc);
      bus.load_addr = ld_a;
      bus.load_data = ld_d;
      @(negedge CLK);
      if (bus.busywait) begin
        n++;
        chk({tag, "_hold_instr"}, bus.instruction, last_instr);
        chk({tag, "_hold_err"}, 32'(bus.err), 32'(last_err));
      end else begin
        done  = 1'b1;
        obs_i = bus.instruction;
        obs_e = bus.err;
      end
      next_cycle();
    end
    bus.load_en = 1'b0;
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    e = exp_q.pop_front();
    chk({tag, "_instr"}, obs_i, e[31:0]);
    chk({tag, "_err"}, 32'(obs_e), 32'(e[32]));
    last_instr = e[31:0];
    last_err   = e[32];
  endtask

  initial begin
    RESET         = 1'b1;
    bus.address   = '0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_busy", 32'(bus.busywait), 32'h1);
    next_cycle();
    RESET = 1'b0;

    preload(32'h00, M0);
    preload(32'h04, M1);
    preload(32'h08, M2);
    preload(32'h10, M4);
    preload(32'h14, M5A);
    preload(32'h20, M8A);
    preload(32'h40, M16);

    // Reset pulse, then first fetch pays full latency.
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0;
    last_instr = '0;
    last_err   = 1'b0;
    fetch("first", 32'h00, M0, 1'b0, FULL, -1, '0, '0);
    fetch("seq", 32'h04, M1, 1'b0, FULL, -1, '0, '0);

    // Redirect from 8 to 0x40 in cycle 2: the 8 fetch must never surface.
    bus.address = 32'h08;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("redir_busy", 32'(bus.busywait), 32'h1);
      chk("redir_hold", bus.instruction, last_instr);
      next_cycle();
    end
    fetch("redirect", 32'h40, M16, 1'b0, FULL, -1, '0, '0);

    // Load over the served word while idle forces a refetch of the new data.
    fetch("reserve4", 32'h04, M1, 1'b0, FULL, -1, '0, '0);
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h04;
    bus.load_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("coh_idle_busy", 32'(bus.busywait), 32'h0);
    next_cycle();
    bus.load_en = 1'b0;
    fetch("coherent", 32'h04, 32'hDEAD_BEEF, 1'b0, FULL, -1, '0, '0);

    // Load hits the requested word on the completion edge: load wins, latency restarts.
    fetch("loadwin", 32'h20, M8B, 1'b0, FULL + LAT, LAT, 32'h20, M8B);

    // Reset in cycle 2 of a fetch of 0x10 clears the output and restarts the fetch.
    bus.address = 32'h10;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("rstmid_busy", 32'(bus.busywait), 32'h1);
      next_cycle();
    end
    RESET = 1'b1;
    @(negedge CLK);
    chk("rstmid_busy_c2", 32'(bus.busywait), 32'h1);
    next_cycle();
    RESET = 1'b0;
    last_instr = '0;
    last_err   = 1'b0;
    fetch("rst_mid", 32'h10, M4, 1'b0, FULL, -1, '0, '0);

    // A load presented during reset must not reach memory.
    RESET         = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 32'h14;
    bus.load_data = M5B;
    next_cycle();
    RESET       = 1'b0;
    bus.load_en = 1'b0;
    last_instr  = '0;
    last_err    = 1'b0;
    fetch("rst_load", 32'h14, M5A, 1'b0, FULL, -1, '0, '0);

`ifdef IMEM_ERR_CHECK_EN
    fetch("err_bad", 32'h402, IMEM_NOP, 1'b1, FULL, -1, '0, '0);
    fetch("err_clr", 32'h00, M0, 1'b0, FULL, -1, '0, '0);
`else
    fetch("trunc", 32'h402, M0, 1'b0, FULL, -1, '0, '0);
    fetch("trunc_mis", 32'h06, 32'hDEAD_BEEF, 1'b0, FULL, -1, '0, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
